// File: rtl/array_mul_sequencer.sv
// array_mul_sequencer
// Drives one shared CORE_W x CORE_W array multiplier over four partial-product
// steps to form a (2*CORE_W) x (2*CORE_W) unsigned product, with a
// start/busy/done handshake toward the requester.
// Optional feature macro: MUL_ACC_EN (multiply-accumulate, adds acc_clr and
// widens the result by four guard bits).
module array_mul_sequencer #(
   parameter  int CORE_W = 4,
   localparam int W      = 2 * CORE_W,
`ifdef MUL_ACC_EN
   localparam int PW     = 2 * W + 4
`else
   localparam int PW     = 2 * W
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          start,
`ifdef MUL_ACC_EN
   input  logic          acc_clr,
`endif
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [1:0]        step_r;
   logic [W-1:0]      a_r;
   logic [W-1:0]      b_r;
   logic [PW-1:0]     acc_r;
   logic [PW-1:0]     product_r;
   logic              accept_s;
   logic [PW-1:0]     acc_seed_s;
   logic [CORE_W-1:0] core_a_s;
   logic [CORE_W-1:0] core_b_s;
   logic [2*CORE_W-1:0] core_p_s;
   logic [PW-1:0]     core_ext_s;
   logic [PW-1:0]     term_s;

   // Shared core: AND-gate partial products summed row by row (array multiplier).
   function automatic logic [2*CORE_W-1:0] core_mul(
      input logic [CORE_W-1:0] x,
      input logic [CORE_W-1:0] y
   );
      logic [2*CORE_W-1:0] sum;
      sum = {(2*CORE_W){1'b0}};
      for (int i = 0; i < CORE_W; i++) begin
         sum = sum + ((2*CORE_W)'(x & {CORE_W{y[i]}}) << i);
      end
      return sum;
   endfunction

   assign accept_s = ena & start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign product  = product_r;

   // Select the accumulator start value for a newly accepted operation.
   always_comb begin
      acc_seed_s = {PW{1'b0}};
`ifdef MUL_ACC_EN
      if (acc_clr) begin
         acc_seed_s = {PW{1'b0}};
      end else begin
         acc_seed_s = product_r;
      end
`endif
   end

   // Mux operand halves into the core by step and align the partial product.
   always_comb begin
      core_a_s   = step_r[0] ? a_r[W-1:CORE_W] : a_r[CORE_W-1:0];
      core_b_s   = step_r[1] ? b_r[W-1:CORE_W] : b_r[CORE_W-1:0];
      core_p_s   = core_mul(core_a_s, core_b_s);
      core_ext_s = PW'(core_p_s);
      case (step_r)
         2'd0:       term_s = core_ext_s;
         2'd1, 2'd2: term_s = core_ext_s << CORE_W;
         2'd3:       term_s = core_ext_s << (2 * CORE_W);
         default:    term_s = core_ext_s;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; every transition is qualified by ena.
   always_comb begin
      state_nxt_s = state_r;
      if (ena) begin
         case (state_r)
            ST_IDLE: state_nxt_s = start ? ST_MUL : ST_IDLE;
            ST_MUL:  state_nxt_s = (step_r == 2'd3) ? ST_DONE : ST_MUL;
            ST_DONE: state_nxt_s = start ? ST_MUL : ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM outputs decoded from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_r)
         ST_IDLE: begin busy = 1'b0; done = 1'b0; end
         ST_MUL:  begin busy = 1'b1; done = 1'b0; end
         ST_DONE: begin busy = 1'b0; done = 1'b1; end
         default: begin busy = 1'b0; done = 1'b0; end
      endcase
   end

   // Datapath: latch operands on accept, accumulate one term per step, publish on the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= {W{1'b0}};
         b_r       <= {W{1'b0}};
         step_r    <= 2'd0;
         acc_r     <= {PW{1'b0}};
         product_r <= {PW{1'b0}};
      end else if (ena) begin
         if (accept_s) begin
            a_r    <= a;
            b_r    <= b;
            step_r <= 2'd0;
            acc_r  <= acc_seed_s;
         end else if (state_r == ST_MUL) begin
            if (step_r == 2'd3) begin
               product_r <= acc_r + term_s;
               step_r    <= 2'd0;
            end else begin
               acc_r  <= acc_r + term_s;
               step_r <= step_r + 2'd1;
            end
         end
      end
   end

endmodule
